// File: rtl/viterbi_decoder_k3.sv
// viterbi_decoder_k3
//   Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code
//   (generators 7, 5 octal). Register-exchange survivors give a fixed decode
//   latency of TB_DEPTH symbols; path metrics are min-normalized each symbol.
//
// Parameters
//   TB_DEPTH  survivor length in symbols and decode latency (>= 4)
//   PM_W      path-metric width; metrics saturate at 2^PM_W-1 (>= 4)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears all state
//   enable_i  d_in holds a valid channel symbol this cycle
//   d_in      channel symbol, [1] = g0 (111) bit, [0] = g1 (101) bit
//   valid_o   one-cycle pulse: d_out holds a decoded bit
//   d_out     decoded data bit, oldest first
//   err_ct_o  (only with VITERBI_ERR_CNT_EN) saturating 16-bit count of
//             channel bit errors along the maximum-likelihood path
//
// Optional feature macro: VITERBI_ERR_CNT_EN
module viterbi_decoder_k3 #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [1:0]  d_in,
  output logic        valid_o,
  output logic        d_out
`ifdef VITERBI_ERR_CNT_EN
  ,
  output logic [15:0] err_ct_o
`endif
);

  localparam int              CNT_W   = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0] PM_MAX  = '1;
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(3);

  logic [PM_W-1:0]     pm      [4];
  logic [TB_DEPTH-1:0] surv    [4];
  logic [CNT_W-1:0]    fill;

  logic [PM_W-1:0]     c0      [4];
  logic [PM_W-1:0]     c1      [4];
  logic [PM_W-1:0]     cand    [4];
  logic [PM_W-1:0]     pm_nx   [4];
  logic [TB_DEPTH-1:0] surv_nx [4];
  logic [PM_W-1:0]     m;
  logic [1:0]          best;

  // Hamming distance between the received symbol and the symbol emitted
  // when input d leaves state p.
  function automatic logic [1:0] branch_metric(input logic [1:0] sym,
                                               input logic [1:0] p,
                                               input logic       d);
    logic [1:0] x;
    x = sym ^ {d ^ p[1] ^ p[0], d ^ p[0]};
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                              input logic [1:0]      bm);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, bm};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

`ifdef VITERBI_ERR_CNT_EN
  function automatic logic [15:0] sat_err(input logic [15:0]     a,
                                          input logic [PM_W-1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + 17'(inc);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
`endif

  // Add-compare-select, normalization and best-state pick, all in one cycle.
  // Next state i = {d, b}: d = i/2, predecessors {b,0} = 2b and {b,1} = 2b+1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      c0[i] = sat_add(pm[2*(i%2)],
                      branch_metric(d_in, 2'(2*(i%2)), 1'(i/2)));
      c1[i] = sat_add(pm[2*(i%2)+1],
                      branch_metric(d_in, 2'(2*(i%2)+1), 1'(i/2)));
      // Tie goes to the {b,0} predecessor.
      if (c1[i] < c0[i]) begin
        cand[i]    = c1[i];
        surv_nx[i] = {surv[2*(i%2)+1][TB_DEPTH-2:0], 1'(i/2)};
      end else begin
        cand[i]    = c0[i];
        surv_nx[i] = {surv[2*(i%2)][TB_DEPTH-2:0], 1'(i/2)};
      end
    end
    m = cand[0];
    for (int i = 1; i < 4; i++)
      if (cand[i] < m) m = cand[i];
    for (int i = 0; i < 4; i++)
      pm_nx[i] = cand[i] - m;
    // Strict compare keeps the lowest index on ties.
    best = 2'd0;
    for (int i = 1; i < 4; i++)
      if (pm_nx[i] < pm_nx[best]) best = 2'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pm[0] <= '0;
      for (int i = 1; i < 4; i++) pm[i] <= PM_INIT;
      for (int i = 0; i < 4; i++) surv[i] <= '0;
      fill    <= '0;
      valid_o <= 1'b0;
      d_out   <= 1'b0;
`ifdef VITERBI_ERR_CNT_EN
      err_ct_o <= '0;
`endif
    end else begin
      valid_o <= 1'b0;
      if (enable_i) begin
        for (int i = 0; i < 4; i++) begin
          pm[i]   <= pm_nx[i];
          surv[i] <= surv_nx[i];
        end
        if (fill != CNT_W'(TB_DEPTH)) fill <= fill + 1'b1;
        // This symbol completes (or follows) the first TB_DEPTH accepted.
        valid_o <= (fill >= CNT_W'(TB_DEPTH - 1));
        d_out   <= surv_nx[best][TB_DEPTH-1];
`ifdef VITERBI_ERR_CNT_EN
        err_ct_o <= sat_err(err_ct_o, m);
`endif
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// tb_viterbi_decoder_k3
//   Scoreboard bench for viterbi_decoder_k3. Data bits are pushed to a queue
//   as their encoded symbols are driven and popped when valid_o pulses.
//   A second instance with PM_W=4 takes a long inverted burst.
module tb_viterbi_decoder_k3;

  localparam int TBD = 16;
  localparam int NB  = 256;
  localparam int NS  = 120;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, enable_i = 1'b0, valid_o, d_out;
  logic [1:0] d_in = 2'b00;
  logic       rst_s = 1'b1, en_s = 1'b0, vld_s, dout_s;
  logic [1:0] din_s = 2'b00;
`ifdef VITERBI_ERR_CNT_EN
  logic [15:0] err_ct_o, err_s;
`endif

  viterbi_decoder_k3 #(.TB_DEPTH(TBD), .PM_W(5)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .d_in(d_in),
    .valid_o(valid_o), .d_out(d_out)
`ifdef VITERBI_ERR_CNT_EN
    , .err_ct_o(err_ct_o)
`endif
  );

  viterbi_decoder_k3 #(.TB_DEPTH(TBD), .PM_W(4)) dut_s (
    .clk(clk), .rst(rst_s), .enable_i(en_s), .d_in(din_s),
    .valid_o(vld_s), .d_out(dout_s)
`ifdef VITERBI_ERR_CNT_EN
    , .err_ct_o(err_s)
`endif
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc_sym(input logic [1:0] s, input logic d);
    return {d ^ s[1] ^ s[0], d ^ s[0]};
  endfunction

  // Scoreboard and monitor for the main instance.
  logic exp_q[$];
  int   n_out   = 0;
  logic en_prev = 1'b0;
  logic mon_rst = 1'b0;
  logic [1:0] enc_s = 2'b00;

  always @(negedge clk) begin
    if (mon_rst) begin
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_dout", 32'(d_out), 32'd0);
    end
    if (!en_prev && valid_o) chk("valid_after_idle", 32'(valid_o), 32'd0);
    if (valid_o) begin
      n_out++;
      if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else chk("dout", 32'(d_out), 32'(exp_q.pop_front()));
    end
    en_prev = enable_i;
  end

  // Monitor for the saturation instance: bits well clear of the burst.
  logic sat_data [NS];
  int   sj = 0;
  always @(negedge clk) begin
    if (vld_s) begin
      if (sj < 14 || (sj >= 86 && sj < NS)) chk("sat_dout", 32'(dout_s), 32'(sat_data[sj]));
      sj++;
    end
  end

  task automatic send(input logic d, input logic [1:0] flip);
    @(posedge clk); #1;
    enable_i = 1'b1;
    d_in     = enc_sym(enc_s, d) ^ flip;
    enc_s    = {d, enc_s[1]};
    exp_q.push_back(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      enable_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; enable_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    enc_s = 2'b00;
    n_out = 0;
  endtask

  logic data [NB];
  logic [1:0] ss;

  initial begin
    // Reset behaviour
    mon_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst_s = 1'b0;
    idle(10);
    @(negedge clk);
    mon_rst = 1'b0;

    // Clean known sequence 1,0,1,1 then zeros
    do_reset();
    send(1'b1, 2'b00); send(1'b0, 2'b00); send(1'b1, 2'b00); send(1'b1, 2'b00);
    for (int k = 4; k < 24; k++) send(1'b0, 2'b00);
    idle(4);
    chk("clean_nout", 32'(n_out), 32'(24 - TBD + 1));

    // Error correction: both bits of every 16th symbol inverted
    for (int k = 0; k < NB; k++) data[k] = 1'($urandom_range(1));
    do_reset();
    for (int k = 0; k < NB; k++) send(data[k], (k % 16 == 0) ? 2'b11 : 2'b00);
    idle(4);
    chk("err_nout", 32'(n_out), 32'(NB - TBD + 1));
`ifdef VITERBI_ERR_CNT_EN
    chk("err_ct", 32'(err_ct_o), 32'd32);
`endif

    // Same stream with random enable gaps
    do_reset();
    for (int k = 0; k < NB; k++) begin
      while ($urandom_range(99) < 30) idle(1);
      send(data[k], (k % 16 == 0) ? 2'b11 : 2'b00);
    end
    idle(4);
    chk("gap_nout", 32'(n_out), 32'(NB - TBD + 1));
`ifdef VITERBI_ERR_CNT_EN
    chk("gap_err_ct", 32'(err_ct_o), 32'd32);
`endif

    // Mid-stream reset, with a symbol presented during rst
    do_reset();
    for (int k = 0; k < 20; k++) send(data[k], 2'b00);
    @(posedge clk); #1;
    rst = 1'b1; enable_i = 1'b1; d_in = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0; enable_i = 1'b0;
    exp_q.delete(); enc_s = 2'b00; n_out = 0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    for (int k = 0; k < 40; k++) send(data[100 + k], 2'b00);
    idle(4);
    chk("mid_nout", 32'(n_out), 32'(40 - TBD + 1));

    // Saturation with PM_W=4: symbols 30..69 inverted
    for (int k = 0; k < NS; k++) sat_data[k] = 1'($urandom_range(1));
    ss = 2'b00;
    for (int k = 0; k < NS; k++) begin
      @(posedge clk); #1;
      en_s  = 1'b1;
      din_s = enc_sym(ss, sat_data[k]) ^ ((k >= 30 && k < 70) ? 2'b11 : 2'b00);
      ss    = {sat_data[k], ss[1]};
    end
    @(posedge clk); #1 en_s = 1'b0;
    repeat (3) @(posedge clk);
    chk("sat_nout", 32'(sj), 32'(NS - TBD + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder_k3.md
# viterbi_decoder_k3

- Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code with generators 7 and 5 (octal).
- Sits at the receive end of the tx/rx chain. It consumes 2-bit channel symbols from the encoder path, including any injected bit errors, and emits the recovered data bit stream.
- Uses register-exchange survivor storage, so latency is fixed at TB_DEPTH symbols.
- Path metrics are min-normalized every symbol.

## Interface
- TB_DEPTH, 16, survivor length in symbols; also the decode latency (≥4).
- PM_W, 5, path-metric width in bits (≥4); metrics saturate at 2^PM_W−1.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high; all state cleared on the clock edge where rst=1.
- enable_i  in  1  d_in carries a valid channel symbol this cycle.
- d_in  in  2  channel symbol: [1]=g0 (111) bit, [0]=g1 (101) bit.
- valid_o  out  1  d_out holds a decoded bit; one-cycle pulse per output.
- d_out  out  1  decoded data bit, oldest first.

## Operation
- Trellis state s[1:0]:
  - s[1] = previous input bit, s[0] = the bit before it.
  - Encoder starts in state 0.
  - Input d from state p gives next state {d, p[1]} and expected symbol {d^p[1]^p[0], d^p[0]}.
- Branch metric:
  - Hamming distance (0..2) between d_in and the expected symbol.
- ACS, one step per enable_i=1 cycle, for each next state ns={d,b}:
  - Predecessors are {b,0} and {b,1}.
  - Candidate = PM[pred] + BM, saturating at 2^PM_W−1.
  - Select the smaller candidate; on a tie select pred {b,0}.
  - New survivor = {survivor[pred][TB_DEPTH−2:0], d}, so bit 0 is the newest.
- Normalization:
  - Compute m = min of the 4 new candidates.
  - Subtract m from all 4 before storing, so the best state always holds 0.
- Best state: lowest stored metric; on a tie the lowest index wins.
- Output:
  - d_out = survivor[best][TB_DEPTH−1], taken from the newly computed survivors.
- Fill counter:
  - Counts accepted symbols, saturating at TB_DEPTH.
  - Output is valid once TB_DEPTH symbols have been accepted since reset.
- Reset values:
  - PM[0]=0, PM[1..3]=3.
  - All survivors 0, fill counter 0.
  - valid_o=0, d_out=0.
- enable_i=0:
  - Metrics, survivors and counter hold.
  - valid_o=0, d_out holds its last value.
- rst=1 with enable_i=1 in the same cycle: rst wins, the symbol is discarded.
- No flush/tail handling: the final TB_DEPTH−1 bits of a stream remain inside the block until further symbols are pushed.

## Timing
- All outputs are registered.
- valid_o and d_out update on the edge that captures an enable_i=1 symbol, so they are visible in the following cycle.
- Symbol k (0-based from reset) carries data bit k.
- The first valid_o=1 occurs the cycle after the TB_DEPTH-th enabled symbol, i.e. k=TB_DEPTH−1; at that point d_out = bit 0.
- Thereafter each enabled symbol k produces bit k−TB_DEPTH+1.
- Throughput: one symbol per cycle with enable_i held high; gaps of any length are allowed.
- Critical path: BM → add → compare → min-subtract → best-state select → survivor mux. This must close at the codebase's standard clock; no pipelining inside the ACS.
- Reset mid-stream: valid_o=0 the cycle after rst; a full TB_DEPTH refill is required before the next valid_o.

## Configuration
- Macro VITERBI_ERR_CNT_EN.
- Defined:
  - Adds output err_ct_o, 16 bits, reset 0.
  - On each accepted symbol it adds m, the pre-subtraction minimum, saturating at 0xFFFF.
  - The total therefore equals the channel bit errors on the maximum-likelihood path.
- Undefined: no err_ct_o port and no counter logic. Decode behaviour is identical in both builds.

## Test plan
- Reset behaviour: rst high 3 cycles, enable_i=0 for 10 cycles → valid_o=0 and d_out=0 throughout.
- Clean known sequence: data 1,0,1,1 is sent as symbols 11,10,00,01, then 12 further symbols for data 0 (encoder-generated), TB_DEPTH=16 → first valid_o the cycle after the 16th symbol with d_out=1, then 0,1,1,0… as each further symbol is sent.
- Error correction: 256 random bits are encoded, and both bits of every 16th symbol are inverted → decoded stream equals the input delayed 16 symbols with zero mismatches; with VITERBI_ERR_CNT_EN, err_ct_o=32.
- Enable gaps: the same stream is sent with enable_i low on random 30% of cycles → identical decoded sequence, and valid_o never high in a cycle after an enable_i=0 cycle.
- Mid-stream reset: rst after 20 symbols, then resume with a fresh encoder → valid_o=0 until 16 new symbols are accepted, first d_out = new bit 0.
- Saturation, PM_W=4: 40 consecutive symbols inverted → no metric wraps, and decoding recovers within 16 symbols of the burst ending.
